// File: rtl/vga_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_arb_pkg
//  Description : Shared encodings for the VGA memory-cycle arbiter: arbiter
//                state values and memory-owner codes.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_arb_pkg;

    // Arbiter states; values chosen so the state doubles as the owner code
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G_CRT = 2'd1,
        G_WR  = 2'd2,
        G_RD  = 2'd3
    } arb_state_t;

    // Memory-owner codes presented on mem_owner
    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_CRT  = 2'd1;
    localparam logic [1:0] OWNER_WR   = 2'd2;
    localparam logic [1:0] OWNER_RD   = 2'd3;

endpackage : vga_arb_pkg
`default_nettype wire

// File: rtl/vga_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mem_arb
//  Description : Memory-cycle arbiter sharing the SVGA memory port between CRT
//                refresh fetch, CPU write FIFO drain and CPU read. One-hot
//                grants decoded from registered state, bounded write bursts,
//                and a starvation / FIFO-full boost for CPU writes.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_mem_arb
    import vga_arb_pkg::*;
#(
    parameter int WR_MAX_BURST = 4,   // beats per CPU write grant (1..15)
    parameter int STARVE_LIMIT = 8    // cycles of write starvation before boost (1..255)
) (
    input  logic       mem_clk,
    input  logic       hreset,
    input  logic       crt_req,
    input  logic       cpu_wr_req,
    input  logic       cpu_rd_req,
    input  logic       m_cpu_ff_full,
    input  logic       svga_ack,
    output logic       crt_gnt,
    output logic       cpu_wr_gnt,
    output logic       cpu_rd_gnt,
    output logic [1:0] mem_owner,
    output logic       wr_boost
);

    // Last beat index of a write burst; beat_cnt+1 == WR_MAX_BURST <=> beat_cnt == this
    localparam logic [3:0] c_BEAT_LAST    = 4'(WR_MAX_BURST - 1);
    localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);

    arb_state_t r_state;
    logic [3:0] r_beat_cnt;
    logic [7:0] r_starve_cnt;
    logic       r_wr_boost;

    logic       w_boost;
    arb_state_t w_idle_next;
    logic       w_enter_wr;
    logic       w_wr_exit;

    // Priority decision taken while the port is idle: boost > CRT > read > write
    function automatic arb_state_t idle_decide(
        input logic boost,
        input logic crt,
        input logic rd,
        input logic wr
    );
        arb_state_t nxt;
        nxt = IDLE;
        if (boost)    nxt = G_WR;
        else if (crt) nxt = G_CRT;
        else if (rd)  nxt = G_RD;
        else if (wr)  nxt = G_WR;
        return nxt;
    endfunction

    // Boost request, idle decision and write-burst termination conditions
    always_comb begin
        w_boost     = cpu_wr_req & (m_cpu_ff_full | (r_starve_cnt == c_STARVE_LIMIT));
        w_idle_next = idle_decide(w_boost, crt_req, cpu_rd_req, cpu_wr_req);
        w_enter_wr  = (r_state == IDLE) && (w_idle_next == G_WR);
        // CRT may only cut a non-boosted burst, and only at a beat boundary
        w_wr_exit   = ~cpu_wr_req
                    | (svga_ack & (r_beat_cnt == c_BEAT_LAST))
                    | (svga_ack & crt_req & ~r_wr_boost);
    end

    // Arbiter FSM with write-beat counter and boost flag; every release goes via IDLE
    always_ff @(posedge mem_clk or posedge hreset) begin
        if (hreset) begin
            r_state    <= IDLE;
            r_beat_cnt <= 4'd0;
            r_wr_boost <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state    <= w_idle_next;
                    r_wr_boost <= w_boost;
                    r_beat_cnt <= 4'd0;
                end
                G_CRT: begin
                    if (!crt_req) r_state <= IDLE;
                end
                G_RD: begin
                    if (svga_ack || !cpu_rd_req) r_state <= IDLE;
                end
                G_WR: begin
                    if (w_wr_exit) begin
                        r_state    <= IDLE;
                        r_beat_cnt <= 4'd0;
                        r_wr_boost <= 1'b0;
                    end else if (svga_ack) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_beat_cnt <= 4'd0;
                    r_wr_boost <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts waiting cycles of a pending write, saturating
    always_ff @(posedge mem_clk or posedge hreset) begin
        if (hreset) begin
            r_starve_cnt <= 8'd0;
        end else if (!cpu_wr_req || w_enter_wr) begin
            r_starve_cnt <= 8'd0;
        end else if ((r_state != G_WR) && (r_starve_cnt < c_STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // Grants and owner code decoded from registered state only
    always_comb begin
        crt_gnt    = (r_state == G_CRT);
        cpu_wr_gnt = (r_state == G_WR);
        cpu_rd_gnt = (r_state == G_RD);
        wr_boost   = r_wr_boost;
        case (r_state)
            G_CRT:   mem_owner = OWNER_CRT;
            G_WR:    mem_owner = OWNER_WR;
            G_RD:    mem_owner = OWNER_RD;
            default: mem_owner = OWNER_NONE;
        endcase
    end

endmodule : vga_mem_arb
`default_nettype wire

// File: tb/tb_vga_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_mem_arb
//  Description : Self-checking bench for vga_mem_arb: directed scenarios plus
//                randomized traffic compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_mem_arb;
    import vga_arb_pkg::*;

    localparam int MAXB = 4;
    localparam int LIM  = 8;

    logic       mem_clk = 1'b0;
    logic       hreset = 1'b1;
    logic       crt_req = 1'b0;
    logic       cpu_wr_req = 1'b0;
    logic       cpu_rd_req = 1'b0;
    logic       m_cpu_ff_full = 1'b0;
    logic       svga_ack = 1'b0;
    logic       crt_gnt;
    logic       cpu_wr_gnt;
    logic       cpu_rd_gnt;
    logic [1:0] mem_owner;
    logic       wr_boost;

    int tests = 0;
    int fails = 0;

    vga_mem_arb #(.WR_MAX_BURST(MAXB), .STARVE_LIMIT(LIM)) dut (
        .mem_clk      (mem_clk),
        .hreset       (hreset),
        .crt_req      (crt_req),
        .cpu_wr_req   (cpu_wr_req),
        .cpu_rd_req   (cpu_rd_req),
        .m_cpu_ff_full(m_cpu_ff_full),
        .svga_ack     (svga_ack),
        .crt_gnt      (crt_gnt),
        .cpu_wr_gnt   (cpu_wr_gnt),
        .cpu_rd_gnt   (cpu_rd_gnt),
        .mem_owner    (mem_owner),
        .wr_boost     (wr_boost)
    );

    always #5 mem_clk = ~mem_clk;

    // ---------------- behavioural reference model ----------------
    // owner: 0 none, 1 crt, 2 cpu write, 3 cpu read
    typedef struct {
        int owner;
        int beats;
        bit boost;
        int starve;
    } mstate_t;

    mstate_t m_s = '{0, 0, 1'b0, 0};

    function automatic mstate_t model_next(input mstate_t s, input logic crt, input logic wr,
                                           input logic rd, input logic full, input logic ack);
        mstate_t n;
        n = s;
        if (s.owner == 0) begin
            if (wr && (full || s.starve == LIM)) begin
                n.owner = 2; n.boost = 1'b1;
            end else if (crt) n.owner = 1;
            else if (rd)      n.owner = 3;
            else if (wr)      n.owner = 2;
        end else if (s.owner == 1) begin
            if (!crt) n.owner = 0;
        end else if (s.owner == 3) begin
            if (ack || !rd) n.owner = 0;
        end else begin
            if (!wr || (ack && s.beats + 1 == MAXB) || (ack && crt && !s.boost)) begin
                n.owner = 0; n.beats = 0; n.boost = 1'b0;
            end else if (ack) begin
                n.beats = s.beats + 1;
            end
        end
        if (!wr)                               n.starve = 0;
        else if (s.owner != 2 && n.owner == 2) n.starve = 0;
        else if (s.owner != 2)                 n.starve = (s.starve < LIM) ? s.starve + 1 : LIM;
        return n;
    endfunction

    always @(posedge mem_clk or posedge hreset) begin
        if (hreset) m_s <= '{0, 0, 1'b0, 0};
        else        m_s <= model_next(m_s, crt_req, cpu_wr_req, cpu_rd_req, m_cpu_ff_full, svga_ack);
    end

    // Every cycle: outputs vs model, one-hot grants, gap cycle on handover
    logic [2:0] prev_g = 3'b000;
    always @(negedge mem_clk) begin
        logic [2:0] cur_g;
        logic [2:0] exp_g;
        cur_g = {crt_gnt, cpu_wr_gnt, cpu_rd_gnt};
        exp_g = (m_s.owner == 1) ? 3'b100 : (m_s.owner == 2) ? 3'b010 :
                (m_s.owner == 3) ? 3'b001 : 3'b000;
        tests++;
        if (cur_g !== exp_g || mem_owner !== 2'(m_s.owner) || wr_boost !== m_s.boost) begin
            fails++;
            $display("FAIL model_cmp t=%0t actual gnt=%b owner=%0d boost=%b required gnt=%b owner=%0d boost=%b",
                     $time, cur_g, mem_owner, wr_boost, exp_g, m_s.owner, m_s.boost);
        end
        tests++;
        if ($countones(cur_g) > 1) begin
            fails++;
            $display("FAIL one_hot t=%0t actual gnt=%b required at most one bit", $time, cur_g);
        end
        tests++;
        if (prev_g != 3'b000 && cur_g != 3'b000 && prev_g != cur_g) begin
            fails++;
            $display("FAIL handover_gap t=%0t actual %b->%b required idle cycle between", $time, prev_g, cur_g);
        end
        prev_g <= cur_g;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge mem_clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        crt_req = 0; cpu_wr_req = 0; cpu_rd_req = 0; m_cpu_ff_full = 0; svga_ack = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        hreset = 1;
        cyc(1);
        hreset = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        hreset = 1;
        crt_req = 1; cpu_wr_req = 1; cpu_rd_req = 1; m_cpu_ff_full = 0; svga_ack = 0;
        cyc(3);
        tests++;
        if ({crt_gnt, cpu_wr_gnt, cpu_rd_gnt, mem_owner, wr_boost} !== 6'b0) begin
            fails++;
            $display("FAIL reset_state actual gnt=%b owner=%0d boost=%b required all 0",
                     {crt_gnt, cpu_wr_gnt, cpu_rd_gnt}, mem_owner, wr_boost);
        end
        hreset = 0;
        cyc(1);
        tests++;
        if (crt_gnt !== 1'b1 || cpu_wr_gnt !== 1'b0 || cpu_rd_gnt !== 1'b0 || mem_owner !== 2'd1) begin
            fails++;
            $display("FAIL reset_release_crt actual gnt=%b owner=%0d required gnt=100 owner=1",
                     {crt_gnt, cpu_wr_gnt, cpu_rd_gnt}, mem_owner);
        end
    endtask

    task automatic test_wr_burst();
        logic [9:0] pat;
        pat = 10'b1111011110;
        apply_reset();
        cpu_wr_req = 1; svga_ack = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            tests++;
            if (cpu_wr_gnt !== pat[9-i]) begin
                fails++;
                $display("FAIL wr_burst cycle %0d actual %b required %b", i, cpu_wr_gnt, pat[9-i]);
            end
        end
        clear_inputs();
        cyc(2);
    endtask

    task automatic test_crt_preempt();
        apply_reset();
        cpu_wr_req = 1;
        cyc(1);
        svga_ack = 1;
        cyc(1);
        svga_ack = 0; crt_req = 1;
        cyc(1);
        tests++;
        if (cpu_wr_gnt !== 1'b1) begin
            fails++;
            $display("FAIL preempt_mid_beat actual wr_gnt=%b required 1", cpu_wr_gnt);
        end
        svga_ack = 1;
        cyc(1);
        tests++;
        if (cpu_wr_gnt !== 1'b0 || crt_gnt !== 1'b0) begin
            fails++;
            $display("FAIL preempt_release actual wr=%b crt=%b required 0 0", cpu_wr_gnt, crt_gnt);
        end
        svga_ack = 0;
        cyc(1);
        tests++;
        if (crt_gnt !== 1'b1 || mem_owner !== 2'd1) begin
            fails++;
            $display("FAIL preempt_crt_gnt actual crt=%b owner=%0d required 1 1", crt_gnt, mem_owner);
        end
        clear_inputs();
        cyc(3);
    endtask

    task automatic test_starve_boost();
        apply_reset();
        crt_req = 1; cpu_wr_req = 1;
        cyc(20);
        tests++;
        if (crt_gnt !== 1'b1 || dut.r_starve_cnt !== 8'(LIM)) begin
            fails++;
            $display("FAIL starve_sat actual crt=%b starve=%0d required 1 %0d", crt_gnt, dut.r_starve_cnt, LIM);
        end
        crt_req = 0;
        cyc(1);
        cyc(1);
        tests++;
        if (cpu_wr_gnt !== 1'b1 || wr_boost !== 1'b1) begin
            fails++;
            $display("FAIL starve_boost actual wr=%b boost=%b required 1 1", cpu_wr_gnt, wr_boost);
        end
        crt_req = 1; svga_ack = 1;
        cyc(3);
        tests++;
        if (cpu_wr_gnt !== 1'b1) begin
            fails++;
            $display("FAIL boost_no_preempt actual wr=%b required 1", cpu_wr_gnt);
        end
        cyc(1);
        tests++;
        if (cpu_wr_gnt !== 1'b0 || wr_boost !== 1'b0) begin
            fails++;
            $display("FAIL boost_burst_end actual wr=%b boost=%b required 0 0", cpu_wr_gnt, wr_boost);
        end
        clear_inputs();
        cyc(3);
    endtask

    task automatic test_full_boost();
        apply_reset();
        cpu_wr_req = 1; m_cpu_ff_full = 1; crt_req = 1; cpu_rd_req = 1;
        cyc(1);
        tests++;
        if (cpu_wr_gnt !== 1'b1 || wr_boost !== 1'b1 || mem_owner !== 2'd2) begin
            fails++;
            $display("FAIL full_boost actual wr=%b boost=%b owner=%0d required 1 1 2", cpu_wr_gnt, wr_boost, mem_owner);
        end
        svga_ack = 1;
        cyc(3);
        tests++;
        if (cpu_wr_gnt !== 1'b1) begin
            fails++;
            $display("FAIL full_no_preempt actual wr=%b required 1", cpu_wr_gnt);
        end
        cyc(1);
        tests++;
        if (cpu_wr_gnt !== 1'b0) begin
            fails++;
            $display("FAIL full_burst_end actual wr=%b required 0", cpu_wr_gnt);
        end
        clear_inputs();
        cyc(3);
    endtask

    task automatic test_reset_mid_rd();
        apply_reset();
        cpu_rd_req = 1;
        cyc(1);
        tests++;
        if (cpu_rd_gnt !== 1'b1 || mem_owner !== 2'd3) begin
            fails++;
            $display("FAIL rd_grant actual rd=%b owner=%0d required 1 3", cpu_rd_gnt, mem_owner);
        end
        #1;
        hreset = 1;
        #1;
        tests++;
        if (cpu_rd_gnt !== 1'b0 || mem_owner !== 2'd0 || dut.r_state !== IDLE ||
            dut.r_beat_cnt !== 4'd0 || dut.r_starve_cnt !== 8'd0) begin
            fails++;
            $display("FAIL async_reset actual rd=%b owner=%0d state=%0d required 0 0 0",
                     cpu_rd_gnt, mem_owner, dut.r_state);
        end
        clear_inputs();
        cyc(1);
        hreset = 0;
        cyc(1);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) crt_req    = ~crt_req;
            if ($urandom_range(9) == 0) cpu_wr_req = ~cpu_wr_req;
            if ($urandom_range(5) == 0) cpu_rd_req = ~cpu_rd_req;
            m_cpu_ff_full = ($urandom_range(15) == 0);
            svga_ack      = $urandom_range(1) == 1;
            cyc(1);
        end
        clear_inputs();
        cyc(3);
    endtask

    initial begin
        test_reset();
        test_wr_burst();
        test_crt_preempt();
        test_starve_boost();
        test_full_boost();
        test_reset_mid_rd();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_vga_mem_arb
`default_nettype wire
